note_sequencer: RTL and testbench

- Parametrised successor to the fixed-song note generator.
- Steps through a chart held in an external synchronous ROM, one ROM word per eighth-note step, and presents the expected-note lane mask to the gameplay scorer.
- Adds the following over the previous generation:
  - configurable lane count, tempo divider and song length;
  - start/restart control;
  - one-shot or looping playback;
  - a per-step strobe;
  - a done flag.
- Sits between the chart ROM and the hit-judge/scoring logic.

---
 rtl/gameplay_pkg.sv | 10 +
 rtl/tempo_tick.sv | 30 +++
 rtl/note_sequencer.sv | 114 +++++++++++
 tb/tb_note_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gameplay_pkg.sv
// gameplay_pkg: shared state encoding and default timing/chart constants for the gameplay blocks
package gameplay_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, PLAY, DONE} seq_state_e;

    localparam int EIGHTH_NOTE_DIV = 13157895;
    localparam int NUM_LANES       = 5;
    localparam int SONG_STEPS      = 304;

endpackage

// File: rtl/tempo_tick.sv
// tempo_tick: modulo-DIV cycle counter with enable and synchronous clear, strobing on terminal count
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   en_i   - count enable (low freezes the count)
//   clr_i  - synchronous clear, wins over en_i
//   tc_o   - high in the enabled cycle whose edge wraps the count from DIV-1 to 0
module tempo_tick #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: steps through an external chart ROM one word per tempo tick and presents the expected-note mask
//   CLOCK_50  - clock;  resetn - asynchronous active-low reset
//   start     - pulse, begins playback from step 0 in IDLE or DONE
//   restart   - pulse, re-begins playback from step 0 in any state (beats start, pause and tick)
//   pause     - level, freezes tempo and step while playing
//   loop_en   - level, wrap to step 0 after the last step instead of stopping
//   rom_addr  - chart ROM address;  rom_data - chart word, valid one cycle after rom_addr
//   exp_notes - lane mask of the current step;  step - current step index
//   step_pulse- one-cycle strobe on each step advance;  playing - PRIME or PLAY;  done - DONE
module note_sequencer
    import gameplay_pkg::*;
#(
    parameter int LANES    = NUM_LANES,
    parameter int TICK_DIV = EIGHTH_NOTE_DIV,
    parameter int STEP_W   = 9,
    parameter int SONG_LEN = SONG_STEPS
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic              restart,
    input  logic              pause,
    input  logic              loop_en,
    output logic [STEP_W-1:0] rom_addr,
    input  logic [LANES-1:0]  rom_data,
    output logic [LANES-1:0]  exp_notes,
    output logic [STEP_W-1:0] step,
    output logic              step_pulse,
    output logic              playing,
    output logic              done
);

    localparam logic [STEP_W-1:0] LAST = STEP_W'(SONG_LEN - 1);

    seq_state_e        state_q, state_d;
    logic              prime_q, prime_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [LANES-1:0]  notes_q, notes_d;
    logic              pulse_q, pulse_d;
    logic              tick;

    // The counter is held at zero outside PLAY so every PLAY entry starts a full step.
    tempo_tick #(.DIV(TICK_DIV)) u_tick (
        .clk_i  (CLOCK_50),
        .rst_ni (resetn),
        .en_i   (state_q == PLAY && !pause),
        .clr_i  (restart || state_q != PLAY),
        .tc_o   (tick)
    );

    // Outside PLAY the ROM is parked on word 0, so the first word is already
    // on rom_data by the second PRIME cycle. In PLAY the next word is prefetched;
    // with TICK_DIV >= 2 rom_data is valid at every tick boundary.
    assign rom_addr   = (state_q == PLAY && step_q != LAST) ? step_q + 1'b1 : '0;
    assign exp_notes  = notes_q;
    assign step       = step_q;
    assign step_pulse = pulse_q;
    assign playing    = state_q == PRIME || state_q == PLAY;
    assign done       = state_q == DONE;

    always_comb begin
        state_d = state_q;
        prime_d = 1'b0;
        step_d  = step_q;
        notes_d = notes_q;
        pulse_d = 1'b0;
        if (restart) begin
            state_d = PRIME;
            notes_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) state_d = PRIME;
                PRIME: begin
                    prime_d = 1'b1;
                    if (prime_q) begin
                        state_d = PLAY;
                        prime_d = 1'b0;
                        step_d  = '0;
                        notes_d = rom_data;
                        pulse_d = 1'b1;
                    end
                end
                PLAY: begin
                    if (tick && (step_q != LAST || loop_en)) begin
                        step_d  = (step_q == LAST) ? '0 : step_q + 1'b1;
                        notes_d = rom_data;
                        pulse_d = 1'b1;
                    end else if (tick) begin
                        state_d = DONE;
                        notes_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            prime_q <= 1'b0;
            step_q  <= '0;
            notes_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prime_q <= prime_d;
            step_q  <= step_d;
            notes_q <= notes_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scenarios plus randomized run against a countdown-based reference model
module tb_note_sequencer;

    localparam int LANES = 5;
    localparam int TICK  = 4;
    localparam int SW    = 3;
    localparam int LEN   = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             restart = 1'b0;
    logic             pause = 1'b0;
    logic             loop_en = 1'b0;
    logic [SW-1:0]    rom_addr, step;
    logic [LANES-1:0] rom_data = '0;
    logic [LANES-1:0] exp_notes;
    logic             step_pulse, playing, done;
    logic [LANES-1:0] rom_mem [0:7];
    logic [LANES-1:0] words   [0:3];
    logic [2*SW+LANES+2:0] obs;
    int total = 0;
    int bad   = 0;

    note_sequencer #(.LANES(LANES), .TICK_DIV(TICK), .STEP_W(SW), .SONG_LEN(LEN)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .start      (start),
        .restart    (restart),
        .pause      (pause),
        .loop_en    (loop_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .exp_notes  (exp_notes),
        .step       (step),
        .step_pulse (step_pulse),
        .playing    (playing),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_mem[rom_addr];
    assign obs = {rom_addr, step, exp_notes, step_pulse, playing, done};

    // Reference model: a priming countdown, the current step (-1 when not
    // stepping) and the cycles left before the next step.
    int               m_prime, m_cur, m_wait, m_step;
    logic             m_done, m_pulse;
    logic [LANES-1:0] m_notes;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_prime = 0; m_cur = -1; m_wait = 0; m_step = 0;
            m_done = 1'b0; m_pulse = 1'b0; m_notes = '0;
        end else begin
            m_pulse = 1'b0;
            if (restart) begin
                m_prime = 2; m_cur = -1; m_done = 1'b0; m_notes = '0;
            end else if (m_prime > 0) begin
                m_prime--;
                if (m_prime == 0) begin
                    m_cur = 0; m_step = 0; m_notes = words[0]; m_wait = TICK; m_pulse = 1'b1;
                end
            end else if (m_cur >= 0) begin
                if (!pause) m_wait--;
                if (m_wait == 0) begin
                    if (m_cur < LEN - 1 || loop_en) begin
                        m_cur = (m_cur + 1) % LEN; m_step = m_cur; m_notes = words[m_cur];
                        m_wait = TICK; m_pulse = 1'b1;
                    end else begin
                        m_cur = -1; m_done = 1'b1; m_notes = '0;
                    end
                end
            end else if (start) begin
                m_prime = 2; m_done = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; start = 1'b0; restart = 1'b0; pause = 1'b0; loop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        cyc();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_values: got %b want %b", obs, 14'b0);
        end
        do_reset();
        repeat (3) cyc();
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want %b", obs, 14'b0);
        end
    endtask

    task automatic test_basic();
        do_reset();
        pulse_start();
        for (int c = 1; c <= 20; c++) begin
            int k;
            logic [2*SW+LANES+2:0] want;
            cyc();
            k = (c >= 2 && c < 18) ? (c - 2) / 4 : -1;
            want = {(k >= 0 && k < 3) ? SW'(k + 1) : SW'(0),
                    k >= 0 ? SW'(k) : (c >= 18 ? SW'(3) : SW'(0)),
                    k >= 0 ? words[k] : 5'b0,
                    (k >= 0 && (c - 2) % 4 == 0) ? 1'b1 : 1'b0,
                    c < 18 ? 1'b1 : 1'b0,
                    c >= 18 ? 1'b1 : 1'b0};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL basic_pass c=%0d: got %b want %b", c, obs, want);
            end
        end
    endtask

    task automatic test_loop();
        do_reset();
        loop_en = 1'b1;
        pulse_start();
        for (int c = 1; c <= 52; c++) begin
            cyc();
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL loop_done c=%0d: got %b want 0", c, done);
            end
            if (c >= 2 && (c - 2) % 4 == 0) begin
                int k;
                k = ((c - 2) / 4) % 4;
                total++;
                if ({step, exp_notes, step_pulse} !== {SW'(k), words[k], 1'b1}) begin
                    bad++;
                    $display("FAIL loop_step c=%0d: got %b want %b", c,
                             {step, exp_notes, step_pulse}, {SW'(k), words[k], 1'b1});
                end
            end
        end
        loop_en = 1'b0;
    endtask

    task automatic test_pause();
        do_reset();
        pulse_start();
        for (int c = 1; c <= 24; c++) begin
            logic [LANES:0] want;
            pause = (c >= 8 && c <= 17);
            cyc();
            want = {(c == 2 || c == 6 || c == 20 || c == 24) ? 1'b1 : 1'b0,
                    c < 2 ? 5'b0 : c < 6 ? words[0] : c < 20 ? words[1] : c < 24 ? words[2] : words[3]};
            total++;
            if ({step_pulse, exp_notes} !== want) begin
                bad++;
                $display("FAIL pause c=%0d: got %b want %b", c, {step_pulse, exp_notes}, want);
            end
        end
        pause = 1'b0;
    endtask

    task automatic test_restart();
        do_reset();
        pulse_start();
        for (int c = 1; c <= 22; c++) begin
            logic [SW+LANES:0] want;
            restart = (c == 14);
            pause   = (c == 14);
            cyc();
            want = {c < 6 ? SW'(0) : c < 10 ? SW'(1) : c < 16 ? SW'(2) : c < 20 ? SW'(0) : SW'(1),
                    (c == 2 || c == 6 || c == 10 || c == 16 || c == 20) ? 1'b1 : 1'b0,
                    c < 2 ? 5'b0 : c < 6 ? words[0] : c < 10 ? words[1] : c < 14 ? words[2] :
                    c < 16 ? 5'b0 : c < 20 ? words[0] : words[1]};
            total++;
            if ({step, step_pulse, exp_notes} !== want) begin
                bad++;
                $display("FAIL restart c=%0d: got %b want %b", c, {step, step_pulse, exp_notes}, want);
            end
        end
        restart = 1'b0;
        pause = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_start();
        repeat (8) cyc();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL async_reset: got %b want %b", obs, 14'b0);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL post_reset_idle c=%0d: got %b want %b", c, obs, 14'b0);
            end
        end
    endtask

    task automatic test_start_ignored();
        do_reset();
        pulse_start();
        for (int c = 1; c <= 24; c++) begin
            int k;
            logic [SW+LANES+2:0] want;
            start = (c == 8 || c == 21);
            cyc();
            k = (c >= 2 && c < 18) ? (c - 2) / 4 : (c >= 23) ? 0 : -1;
            want = {k >= 0 ? SW'(k) : (c >= 18 ? SW'(3) : SW'(0)),
                    k >= 0 ? words[k] : 5'b0,
                    ((c >= 2 && c <= 14 && (c - 2) % 4 == 0) || c == 23) ? 1'b1 : 1'b0,
                    (c < 18 || c >= 21) ? 1'b1 : 1'b0,
                    (c >= 18 && c < 21) ? 1'b1 : 1'b0};
            total++;
            if ({step, exp_notes, step_pulse, playing, done} !== want) begin
                bad++;
                $display("FAIL start_ignored c=%0d: got %b want %b", c,
                         {step, exp_notes, step_pulse, playing, done}, want);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [2*SW+LANES+2:0] want;
            start   = ($urandom_range(0, 9) == 0);
            restart = ($urandom_range(0, 39) == 0);
            pause   = ($urandom_range(0, 3) == 0);
            loop_en = $urandom_range(0, 1) == 1;
            cyc();
            want = {(m_cur >= 0 && m_cur < LEN - 1) ? SW'(m_cur + 1) : SW'(0),
                    SW'(m_step), m_notes, m_pulse,
                    (m_prime > 0 || m_cur >= 0) ? 1'b1 : 1'b0, m_done};
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL random c=%0d: got %b want %b", c, obs, want);
            end
        end
        start = 1'b0; restart = 1'b0; pause = 1'b0; loop_en = 1'b0;
    endtask

    initial begin
        words[0] = 5'b00101;
        words[1] = 5'b01010;
        words[2] = 5'b10100;
        words[3] = 5'b11000;
        for (int i = 0; i < 8; i++) rom_mem[i] = (i < 4) ? words[i] : 5'b11111;
        test_reset();
        test_basic();
        test_loop();
        test_pause();
        test_restart();
        test_async_reset();
        test_start_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
